// File: rtl/md5_candidate_enum_if.sv
// Candidate stream from the enumerator to the MD5 brute-force cores.
// The match reports travel back from the cores over the same bundle.
interface md5_candidate_enum_if #(
  parameter int NUM_LANES = 2
);
  logic                       cand_valid;
  logic                       cand_ready;
  logic [NUM_LANES-1:0]       cand_lane_en;
  logic [512*NUM_LANES-1:0]   cand_str;
  logic [NUM_LANES-1:0]       match_valid;
  logic [512*NUM_LANES-1:0]   match_str;

  modport master (
    output cand_valid, cand_lane_en, cand_str,
    input  cand_ready, match_valid, match_str
  );

  modport slave (
    input  cand_valid, cand_lane_en, cand_str,
    output cand_ready, match_valid, match_str
  );
endinterface

// File: rtl/md5_candidate_enum.sv
// N-symbol, L-lane odometer feeding MD5 brute-force cores; drains and captures the first match.
// Optional MD5_ENUM_PROGRESS_EN adds the cand_count progress output.
module md5_candidate_enum #(
  parameter int         NUM_SYMB     = 2,
  parameter int         NUM_LANES    = 2,
  parameter int         SYMB_POS     = 0,
  parameter logic [7:0] FROM_CHAR    = 8'h20,
  parameter logic [7:0] TO_CHAR      = 8'h7E,
  parameter int         DRAIN_CYCLES = 68
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [511:0]          start_str,
  md5_candidate_enum_if.master  cand_if,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [511:0]          result_str
`ifdef MD5_ENUM_PROGRESS_EN
  ,
  output logic [47:0]           cand_count
`endif
);

  localparam logic [8:0] RADIX = 9'({1'b0, TO_CHAR} - {1'b0, FROM_CHAR} + 9'd1);
  localparam logic [8:0] STEP  = 9'(NUM_LANES);
  localparam int         DCW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [511:0]            tmpl;
  logic [7:0]              dig     [NUM_LANES][NUM_SYMB];
  logic [7:0]              dig_nxt [NUM_LANES][NUM_SYMB];
  logic [NUM_LANES-1:0]    lane_en, lane_en_nxt;
  logic [DCW-1:0]          drain_cnt;
  logic                    active, accept, capture, picked, carry;
  logic [8:0]              sum;
  logic [511:0]            blk, match_sel;
  logic [512*NUM_LANES-1:0] cand_str_c;

  assign active  = (state == S_RUN) || (state == S_DRAIN);
  assign accept  = (state == S_RUN) && cand_if.cand_ready;
  assign capture = active && (|cand_if.match_valid) && !found;

  // Each lane steps by NUM_LANES: add to the low digit, ripple a single carry upward.
  always_comb begin
    sum         = '0;
    carry       = 1'b0;
    lane_en_nxt = lane_en;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      for (int unsigned k = 0; k < NUM_SYMB; k++) dig_nxt[i][k] = dig[i][k];
      sum   = {1'b0, dig[i][0]} + STEP;
      carry = 1'b0;
      if (sum >= RADIX) begin
        sum   = sum - RADIX;
        carry = 1'b1;
      end
      if (lane_en[i]) dig_nxt[i][0] = sum[7:0];
      for (int unsigned k = 1; k < NUM_SYMB; k++) begin
        sum   = {1'b0, dig[i][k]} + {8'd0, carry};
        carry = 1'b0;
        if (sum == RADIX) begin
          sum   = '0;
          carry = 1'b1;
        end
        if (lane_en[i]) dig_nxt[i][k] = sum[7:0];
      end
      lane_en_nxt[i] = lane_en[i] & ~carry;
    end
  end

  always_comb begin
    blk        = '0;
    cand_str_c = '0;
    if (state == S_RUN) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        blk = tmpl;
        for (int unsigned k = 0; k < NUM_SYMB; k++)
          blk[8*(SYMB_POS+k) +: 8] = FROM_CHAR + dig[i][k];
        cand_str_c[512*i +: 512] = blk;
      end
    end
  end

  // Lowest-index reporting core wins when several hit together.
  always_comb begin
    match_sel = '0;
    picked    = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (cand_if.match_valid[i] && !picked) begin
        match_sel = cand_if.match_str[512*i +: 512];
        picked    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    busy                 = active;
    done                 = (state == S_DONE);
    cand_if.cand_valid   = (state == S_RUN);
    cand_if.cand_lane_en = (state == S_RUN) ? lane_en : '0;
    cand_if.cand_str     = cand_str_c;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (capture || abort)                 state_nxt = S_DONE;
        else if (accept && !(|lane_en_nxt))   state_nxt = S_DRAIN;
      end
      S_DRAIN: if (capture || abort || drain_cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmpl       <= '0;
      lane_en    <= '0;
      drain_cnt  <= '0;
      found      <= 1'b0;
      result_str <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++)
        for (int unsigned k = 0; k < NUM_SYMB; k++) dig[i][k] <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        tmpl       <= start_str;
        lane_en    <= '1;
        found      <= 1'b0;
        result_str <= '0;
        for (int unsigned i = 0; i < NUM_LANES; i++)
          for (int unsigned k = 0; k < NUM_SYMB; k++)
            dig[i][k] <= (k == 0) ? 8'(i) : 8'd0;
      end else if (accept) begin
        lane_en <= lane_en_nxt;
        dig     <= dig_nxt;
      end
      if (state == S_RUN && state_nxt == S_DRAIN)
        drain_cnt <= DRAIN_LOAD;
      else if (state == S_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;
      if (capture) begin
        found      <= 1'b1;
        result_str <= match_sel;
      end
    end
  end

`ifdef MD5_ENUM_PROGRESS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      cand_count <= '0;
    else if (state == S_IDLE && start) cand_count <= '0;
    else if (accept)                   cand_count <= cand_count + 48'($countones(lane_en));
  end
`endif

endmodule

// File: tb/tb_md5_candidate_enum.sv
// Scoreboard bench: dut_a uses a 3-letter alphabet, dut_b the default printable range.
module tb_md5_candidate_enum;

  localparam int A_DRAIN = 6;

  typedef struct {
    logic [1:0]    en;
    logic [1023:0] str;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset_n, start_a, start_b, abort, cand_ready, sel;
  logic [511:0]   start_str;
  logic [1:0]     match_valid;
  logic [1023:0]  match_str;
  logic           busy_a, done_a, found_a, busy_b, done_b, found_b;
  logic [511:0]   result_a, result_b;
  logic           obs_valid, obs_busy, obs_done, obs_found;
  logic [1:0]     obs_en;
  logic [1023:0]  obs_str;
  logic [511:0]   obs_result;
`ifdef MD5_ENUM_PROGRESS_EN
  logic [47:0]    count_a, count_b;
`endif

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  md5_candidate_enum_if #(.NUM_LANES(2)) if_a ();
  md5_candidate_enum_if #(.NUM_LANES(2)) if_b ();

  assign if_a.cand_ready  = cand_ready;
  assign if_a.match_valid = match_valid;
  assign if_a.match_str   = match_str;
  assign if_b.cand_ready  = cand_ready;
  assign if_b.match_valid = match_valid;
  assign if_b.match_str   = match_str;

  md5_candidate_enum #(
    .NUM_SYMB(2), .NUM_LANES(2), .SYMB_POS(0),
    .FROM_CHAR(8'h61), .TO_CHAR(8'h63), .DRAIN_CYCLES(A_DRAIN)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort),
    .start_str(start_str), .cand_if(if_a.master),
    .busy(busy_a), .done(done_a), .found(found_a), .result_str(result_a)
`ifdef MD5_ENUM_PROGRESS_EN
    , .cand_count(count_a)
`endif
  );

  md5_candidate_enum dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort),
    .start_str(start_str), .cand_if(if_b.master),
    .busy(busy_b), .done(done_b), .found(found_b), .result_str(result_b)
`ifdef MD5_ENUM_PROGRESS_EN
    , .cand_count(count_b)
`endif
  );

  always_comb begin
    obs_valid  = sel ? if_b.cand_valid   : if_a.cand_valid;
    obs_en     = sel ? if_b.cand_lane_en : if_a.cand_lane_en;
    obs_str    = sel ? if_b.cand_str     : if_a.cand_str;
    obs_busy   = sel ? busy_b            : busy_a;
    obs_done   = sel ? done_b            : done_a;
    obs_found  = sel ? found_b           : found_a;
    obs_result = sel ? result_b          : result_a;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Candidate value v, written in base r with the low digit in byte 0.
  function automatic logic [511:0] model_block(input logic [511:0] tmpl, input int v,
                                               input int r, input logic [7:0] from);
    logic [511:0] blk;
    int rem;
    blk = tmpl;
    rem = v;
    for (int k = 0; k < 2; k++) begin
      blk[8*k +: 8] = from + 8'(rem % r);
      rem = rem / r;
    end
    return blk;
  endfunction

  task automatic fill_q(input logic [511:0] tmpl, input int r, input logic [7:0] from);
    beat_t e;
    int total, nb;
    exp_q.delete();
    total = r * r;
    nb = (total + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      e.str = '0;
      for (int i = 0; i < 2; i++) begin
        e.en[i] = (b * 2 + i) < total;
        e.str[512*i +: 512] = model_block(tmpl, b * 2 + i, r, from);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input bit which_b, input logic [511:0] tmpl);
    @(negedge clk);
    start_str  = tmpl;
    cand_ready = 1'b0;
    if (which_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_beats(input int nbeats, input bit toggle);
    int  got, cyc;
    bit  rdy;
    got = 0;
    cyc = 0;
    while (got < nbeats && cyc < 200 + 4 * nbeats) begin
      @(negedge clk);
      cyc++;
      rdy = toggle ? (cyc % 2 == 1) : 1'b1;
      cand_ready = rdy;
      if (obs_valid) begin
        if (exp_q.size() == 0) begin
          check("beat_extra", 512'(1), 512'(0));
          break;
        end
        check("lane_en", 512'(obs_en), 512'(exp_q[0].en));
        for (int i = 0; i < 2; i++)
          if (exp_q[0].en[i])
            check($sformatf("lane%0d_str", i), obs_str[512*i +: 512], exp_q[0].str[512*i +: 512]);
        if (rdy) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
    end
    check("beat_count", 512'(got), 512'(nbeats));
  endtask

  task automatic wait_done(input int budget, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cand_ready = 1'b0;
      if (obs_done) begin
        seen = 1'b1;
        break;
      end
      cycles++;
    end
    check("done_seen", 512'(seen), 512'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] tmpl, p0, p1;
    int cycles, dones;

    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; cand_ready = 1'b0;
    sel = 1'b0; start_str = '0; match_valid = '0; match_str = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_valid",  512'(obs_valid), 512'(0));
      check("rst_lane_en", 512'(obs_en),   512'(0));
      check("rst_busy",   512'(obs_busy),  512'(0));
      check("rst_done",   512'(obs_done),  512'(0));
      check("rst_found",  512'(obs_found), 512'(0));
      check("rst_str0",   obs_str[511:0],  '0);
      check("rst_result", obs_result,      '0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Full sweep, always ready: 5 beats, last one partial, then drain.
    sel = 1'b0;
    tmpl = rand512();
    fill_q(tmpl, 3, 8'h61);
    pulse_start(1'b0, tmpl);
    check("busy_run", 512'(obs_busy), 512'(1));
    run_beats(5, 1'b0);
    wait_done(200, cycles);
    check("q_empty", 512'(exp_q.size()), 512'(0));
    check("drain_len", 512'(cycles), 512'(A_DRAIN));
    check("sweep_found", 512'(obs_found), 512'(0));
    check("done_valid", 512'(obs_valid), 512'(0));
    check("done_busy", 512'(obs_busy), 512'(0));
`ifdef MD5_ENUM_PROGRESS_EN
    check("cand_count", 512'(count_a), 512'(9));
`endif
    @(negedge clk);
    check("done_one_cycle", 512'(obs_done), 512'(0));

    // Same sweep with cand_ready toggling 1-0-1.
    tmpl = rand512();
    fill_q(tmpl, 3, 8'h61);
    pulse_start(1'b0, tmpl);
    run_beats(5, 1'b1);
    wait_done(200, cycles);
    check("tog_q_empty", 512'(exp_q.size()), 512'(0));
    check("tog_found", 512'(obs_found), 512'(0));

    // Default config: lane1 hit after 100 beats.
    sel = 1'b1;
    tmpl = rand512();
    fill_q(tmpl, 95, 8'h20);
    pulse_start(1'b1, tmpl);
    run_beats(100, 1'b0);
    p0 = rand512();
    p1 = rand512();
    @(negedge clk);
    match_valid = 2'b10;
    match_str = {p1, p0};
    @(negedge clk);
    match_valid = '0;
    cand_ready = 1'b0;
    check("m1_done", 512'(obs_done), 512'(1));
    check("m1_valid", 512'(obs_valid), 512'(0));
    check("m1_found", 512'(obs_found), 512'(1));
    check("m1_result", obs_result, p1);
    @(negedge clk);

    // Both lanes hit together: lane0 wins; a later pulse is ignored.
    tmpl = rand512();
    fill_q(tmpl, 95, 8'h20);
    pulse_start(1'b1, tmpl);
    check("m2_cleared", 512'(obs_found), 512'(0));
    run_beats(3, 1'b0);
    p0 = rand512();
    p1 = rand512();
    @(negedge clk);
    match_valid = 2'b11;
    match_str = {p1, p0};
    @(negedge clk);
    match_valid = '0;
    cand_ready = 1'b0;
    check("m2_done", 512'(obs_done), 512'(1));
    check("m2_result", obs_result, p0);
    repeat (2) @(negedge clk);
    match_valid = 2'b01;
    match_str = {rand512(), rand512()};
    @(negedge clk);
    match_valid = '0;
    @(negedge clk);
    check("m2_hold", obs_result, p0);
    check("m2_hold_found", 512'(obs_found), 512'(1));

    // Reset mid-drain on dut_a; dut_b's captured result must clear too.
    sel = 1'b0;
    tmpl = rand512();
    fill_q(tmpl, 3, 8'h61);
    pulse_start(1'b0, tmpl);
    run_beats(5, 1'b0);
    @(negedge clk);
    cand_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rd_busy", 512'(obs_busy), 512'(1));
    check("rd_valid", 512'(obs_valid), 512'(0));
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rd_busy0", 512'(obs_busy), 512'(0));
    check("rd_found", 512'(obs_found), 512'(0));
    check("rd_result", obs_result, '0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (obs_done) dones++;
    end
    check("rd_no_done", 512'(dones), 512'(0));
    check("rd_idle", 512'(obs_busy), 512'(0));
    sel = 1'b1;
    #1;
    check("rd_b_found", 512'(obs_found), 512'(0));
    check("rd_b_result", obs_result, '0);

    // Abort after 10 beats, then restart from the first candidates.
    tmpl = rand512();
    fill_q(tmpl, 95, 8'h20);
    pulse_start(1'b1, tmpl);
    run_beats(10, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    cand_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("ab_done", 512'(obs_done), 512'(1));
    check("ab_found", 512'(obs_found), 512'(0));
    check("ab_valid", 512'(obs_valid), 512'(0));
    @(negedge clk);
    fill_q(tmpl, 95, 8'h20);
    pulse_start(1'b1, tmpl);
    run_beats(2, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    cand_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("ab2_done", 512'(obs_done), 512'(1));
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md5_candidate_enum.md
Name: md5_candidate_enum

Overview:
Parametrised candidate generator for the MD5 brute-force path. It replaces the fixed 2-symbol, single-core sweep with an N-symbol, L-lane odometer over a programmable character range. Each beat presents L distinct 512-bit message blocks to L downstream MD5 brute-force cores through a valid/ready handshake. It then drains the in-flight hashes, captures the first reported match, and signals completion.

Parameters:
NUM_SYMB, 2, number of enumerated symbol positions (1..8)
NUM_LANES, 2, candidates emitted per beat; must satisfy 1 <= NUM_LANES <= radix
SYMB_POS, 0, byte index in the block of symbol 0; SYMB_POS+NUM_SYMB <= 55
FROM_CHAR, 8'h20, lowest character code
TO_CHAR, 8'h7E, highest character code; radix R = TO_CHAR-FROM_CHAR+1
DRAIN_CYCLES, 68, cycles to wait after the last beat for in-flight core results

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches start_str and begins a sweep (honoured only in IDLE)
abort  in  1  stops the sweep; goes to DONE with found=0
start_str  in  512  template block; padding and length are already set by software
cand_valid  out  1  a beat is presented
cand_ready  in  1  cores accept the beat
cand_lane_en  out  NUM_LANES  per-lane candidate validity within the beat
cand_str  out  512*NUM_LANES  lane i block at bits [512*i +: 512]
match_valid  in  NUM_LANES  core i reports a hash hit (1-cycle pulse)
match_str  in  512*NUM_LANES  matching block from core i
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse on entering DONE
found  out  1  a match was captured in this sweep
result_str  out  512  captured matching block

Behaviour:
- Reset (async assert, sync release): state=IDLE. cand_valid, cand_lane_en, busy, done and found are 0. cand_str and result_str are 0.
- Candidate encoding: lane i holds digits d[0..NUM_SYMB-1], each in 0..R-1. Byte SYMB_POS+k of the block = FROM_CHAR+d[k]; all other bytes come from the latched start_str. Byte b occupies bits [8b +: 8]. d[0] is the fastest-changing digit.
- Lane i is initialised to the value i (d[0]=i, all other digits 0). All lanes are enabled.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start. In the same cycle, latch start_str, initialise the odometers, clear found/result_str and raise busy.
- RUN: cand_valid=1 and cand_str/cand_lane_en are held stable until cand_valid&cand_ready. On acceptance, every enabled lane advances by NUM_LANES:
  - d[0] += NUM_LANES; if d[0] >= R, subtract R and carry 1 into d[1].
  - Each higher digit adds the carry and wraps at R.
  - A carry out of d[NUM_SYMB-1] clears that lane's enable bit. The lane is exhausted and stays disabled.
- RUN -> DRAIN on the acceptance cycle whose advance leaves no lane enabled. The final beat may be partial, e.g. lane_en=01.
- Total candidates = R^NUM_SYMB; number of beats = ceil(R^NUM_SYMB / NUM_LANES).
- DRAIN: cand_valid=0. A counter loads DRAIN_CYCLES-1 and decrements each cycle; at 0 -> DONE.
- Match capture (RUN or DRAIN): on any match_valid bit with found=0, set found=1 and copy match_str of the lowest-index asserted lane into result_str.
  - The FSM then goes to DONE next cycle and cand_valid drops immediately.
  - Later match_valid pulses are ignored until the next start.
- abort in RUN/DRAIN: go to DONE next cycle. A match in the same cycle as abort still captures, because match has priority.
- DONE: done=1 for exactly one cycle and busy=0; then IDLE. found/result_str hold until the next start.
- start outside IDLE is ignored. start and match_valid in IDLE are ignored.
- Asserting reset_n low mid-sweep returns to IDLE with all outputs at reset values; no done pulse.

Optional Feature:
MD5_ENUM_PROGRESS_EN:
- Defined: adds output cand_count[47:0]. It is cleared on start and, on each accepted beat, increments by popcount(cand_lane_en). It is frozen in DONE/IDLE, so it equals R^NUM_SYMB after a full sweep with no match.
- Undefined: the port and counter do not exist.

Test Plan:
- NUM_SYMB=2, NUM_LANES=2, FROM=8'h61, TO=8'h63 (R=3), SYMB_POS=0, cand_ready=1, no match:
  - beat 0: lane0 "aa", lane1 "ba"; beat 1: "ca","ab".
  - 5 beats total, beat 4 lane_en=01 with lane0 "cc".
  - DRAIN lasts DRAIN_CYCLES cycles, then done=1, found=0; cand_count=9.
- Same config, cand_ready toggled 1-0-1 each cycle: cand_str is stable while ready=0; the same 5-beat sequence is produced with no skips or repeats.
- Default config, match_valid=2'b10 pulsed after beat 100: result_str equals lane1 match_str, found=1; done occurs 1 cycle later with cand_valid=0.
- Both match bits asserted in the same cycle: lane0 is captured. A second pulse 3 cycles later leaves result_str unchanged.
- abort asserted in RUN at beat 10 -> done pulse next cycle, found=0; a new start restarts from "aa"/"ba".
- reset_n low for 1 cycle mid-DRAIN -> state IDLE, busy=0, no done pulse, found=0, result_str=0.
